ps2_device_emulator: RTL and testbench

//   Parametrised PS/2 device-side frame generator for system benches and FPGA self-test.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/ps2_device_emulator.sv | 133 +++++++++++++
 tb/tb_ps2_device_emulator.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and frame-payload helper for the PS/2 device emulator.
package ps2_pkg;

   localparam int   PS2_FRAME_BITS = 11;
   localparam logic PS2_START      = 1'b0;
   localparam logic PS2_STOP       = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_LOW   = 2'd2,
      ST_GAP   = 2'd3
   } ps2_state_e;

   // Bits 1..10 of the frame, LSB sent first: data, odd parity (inverted on request), stop.
   function automatic logic [9:0] ps2_payload(input logic [7:0] data, input logic bad_par);
      return {PS2_STOP, (~^data) ^ bad_par, data};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; caller guarantees no write when full and no read when empty.
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_wr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_rd,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;

   // Pointer and occupancy tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_wr) r_wptr <= r_wptr + AW'(1);
         else      r_wptr <= r_wptr;
         if (i_rd) r_rptr <= r_rptr + AW'(1);
         else      r_rptr <= r_rptr;
         case ({i_wr, i_rd})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array, not reset
   always_ff @(posedge clk) begin
      if (i_wr) r_mem[r_wptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rptr];
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/ps2_device_emulator.sv
// PS/2 device-side frame generator: queued bytes are serialised as 11-bit frames on
// registered ps2_clk/ps2_dat with programmable half-period and inter-frame gap.
module ps2_device_emulator
   import ps2_pkg::*;
#(
   parameter int HALF_PERIOD = 4,
   parameter int GAP_CYCLES  = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int CNT_W       = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [7:0]                    in_data,
   input  logic                          in_bad_par,
   output logic                          ps2_clk,
   output logic                          ps2_dat,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [CNT_W-1:0]              frames_sent
);

   localparam int PH_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam logic [PH_W-1:0] HP_LOAD  = PH_W'(HALF_PERIOD - 1);
   localparam logic [PH_W-1:0] GAP_LOAD = PH_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [3:0]      LAST_BIT = 4'(PS2_FRAME_BITS - 1);

   ps2_state_e        r_state;
   logic [PH_W-1:0]   r_phase;
   logic [3:0]        r_bit;
   logic [9:0]        r_shift;
   logic              r_clk;
   logic              r_dat;
   logic [CNT_W-1:0]  r_frames;

   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [8:0]        w_rdata;

   assign w_push = in_valid & in_ready;
   assign w_pop  = (r_state == ST_IDLE) & ~w_empty;

   sync_fifo #(
      .WIDTH (9),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_wr    (w_push),
      .i_wdata ({in_bad_par, in_data}),
      .i_rd    (w_pop),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count)
   );

   // Serialiser FSM: every state entry reloads the phase counter and sets the line registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_phase  <= '0;
         r_bit    <= 4'd0;
         r_shift  <= '1;
         r_clk    <= 1'b1;
         r_dat    <= 1'b1;
         r_frames <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_clk <= 1'b1;
               if (!w_empty) begin
                  r_shift <= ps2_payload(w_rdata[7:0], w_rdata[8]);
                  r_dat   <= PS2_START;
                  r_bit   <= 4'd0;
                  r_phase <= HP_LOAD;
                  r_state <= ST_SETUP;
               end else begin
                  r_dat   <= 1'b1;
               end
            end
            ST_SETUP: begin
               if (r_phase == '0) begin
                  r_clk   <= 1'b0;
                  r_phase <= HP_LOAD;
                  r_state <= ST_LOW;
               end else begin
                  r_phase <= r_phase - PH_W'(1);
               end
            end
            ST_LOW: begin
               if (r_phase != '0) begin
                  r_phase <= r_phase - PH_W'(1);
               end else if (r_bit == LAST_BIT) begin
                  r_frames <= r_frames + CNT_W'(1);
                  r_clk    <= 1'b1;
                  r_dat    <= 1'b1;
                  r_phase  <= GAP_LOAD;
                  r_state  <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
               end else begin
                  // Next bit goes out on the rising edge, so data only moves while ps2_clk is high
                  r_bit   <= r_bit + 4'd1;
                  r_clk   <= 1'b1;
                  r_dat   <= r_shift[0];
                  r_shift <= {1'b1, r_shift[9:1]};
                  r_phase <= HP_LOAD;
                  r_state <= ST_SETUP;
               end
            end
            ST_GAP: begin
               if (r_phase == '0) r_state <= ST_IDLE;
               else               r_phase <= r_phase - PH_W'(1);
            end
            default: begin
               r_clk   <= 1'b1;
               r_dat   <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = ~w_full;
   assign ps2_clk     = r_clk;
   assign ps2_dat     = r_dat;
   assign busy        = (r_state != ST_IDLE) | ~w_empty;
   assign frames_sent = r_frames;

endmodule

// File: tb/tb_ps2_device_emulator.sv
// Scoreboard bench: expected frames are queued when a byte is accepted and compared
// when the monitor has sampled 11 bits on ps2_clk falling edges.
module tb_ps2_device_emulator;

   localparam int HP  = 4;
   localparam int GAP = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // main instance (HP=4, GAP=16)
   logic       m_in_valid = 1'b0, m_in_bad = 1'b0, m_in_ready;
   logic [7:0] m_in_data = 8'h00;
   logic       m_ps2_clk, m_ps2_dat, m_busy;
   logic [2:0] m_fifo_count;
   logic [15:0] m_frames;

   // fast instances share stimulus (HP=1, GAP=0); u_wrap has a 4-bit frame counter
   logic       f_in_valid = 1'b0, f_in_bad = 1'b0, f_in_ready, w_in_ready;
   logic [7:0] f_in_data = 8'h00;
   logic       f_ps2_clk, f_ps2_dat, f_busy, w_ps2_clk, w_ps2_dat, w_busy;
   logic [2:0] f_fifo_count, w_fifo_count;
   logic [15:0] f_frames;
   logic [3:0] w_frames;

   ps2_device_emulator #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP), .FIFO_DEPTH(4), .CNT_W(16)) u_dut (
      .clk(clk), .reset(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
      .in_bad_par(m_in_bad), .ps2_clk(m_ps2_clk), .ps2_dat(m_ps2_dat), .busy(m_busy),
      .fifo_count(m_fifo_count), .frames_sent(m_frames));

   ps2_device_emulator #(.HALF_PERIOD(1), .GAP_CYCLES(0), .FIFO_DEPTH(4), .CNT_W(16)) u_fast (
      .clk(clk), .reset(rst_n), .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data),
      .in_bad_par(f_in_bad), .ps2_clk(f_ps2_clk), .ps2_dat(f_ps2_dat), .busy(f_busy),
      .fifo_count(f_fifo_count), .frames_sent(f_frames));

   ps2_device_emulator #(.HALF_PERIOD(1), .GAP_CYCLES(0), .FIFO_DEPTH(4), .CNT_W(4)) u_wrap (
      .clk(clk), .reset(rst_n), .in_valid(f_in_valid), .in_ready(w_in_ready), .in_data(f_in_data),
      .in_bad_par(f_in_bad), .ps2_clk(w_ps2_clk), .ps2_dat(w_ps2_dat), .busy(w_busy),
      .fifo_count(w_fifo_count), .frames_sent(w_frames));

   logic [10:0] mq[$];
   logic [10:0] fq[$];

   // main monitor state
   int          m_nb = 0, m_prev_fall = 0, m_first = 0, m_last_end = -1, m_span = 0;
   int          m_falls = 0, m_viol = 0;
   bit          m_chk_gap = 1'b0;
   logic        m_pclk = 1'b1, m_pdat = 1'b1;
   logic [10:0] m_bits = '0, m_last_frame = '0;

   // main monitor: sample on negedge, compare each completed frame with the scoreboard
   always @(negedge clk) begin
      logic [10:0] e;
      if (!rst_n) begin
         m_nb = 0;
         m_pclk = 1'b1;
         m_pdat = 1'b1;
      end else begin
         if (!m_pclk && !m_ps2_clk && m_ps2_dat !== m_pdat) m_viol++;
         if (m_pclk && !m_ps2_clk) begin
            m_falls++;
            if (m_nb == 0) begin
               // gap plus the single IDLE pop cycle separate the last fall from the next frame
               if (m_chk_gap && m_last_end >= 0) begin
                  checks++;
                  if (cyc - m_last_end !== 2*HP + GAP + 1) begin
                     errors++;
                     $display("FAIL m_interframe got %0d want %0d", cyc - m_last_end, 2*HP + GAP + 1);
                  end
               end
               m_first = cyc;
            end else begin
               checks++;
               if (cyc - m_prev_fall !== 2*HP) begin
                  errors++;
                  $display("FAIL m_bit_period got %0d want %0d", cyc - m_prev_fall, 2*HP);
               end
            end
            m_bits[m_nb] = m_ps2_dat;
            m_nb++;
            m_prev_fall = cyc;
            if (m_nb == 11) begin
               m_nb = 0;
               m_last_end = cyc;
               m_last_frame = m_bits;
               m_span = cyc - m_first + 2*HP;
               checks++;
               if (mq.size() == 0) begin
                  errors++;
                  $display("FAIL m_frame unexpected frame %b", m_bits);
               end else begin
                  e = mq.pop_front();
                  if (m_bits !== e) begin
                     errors++;
                     $display("FAIL m_frame got %b want %b", m_bits, e);
                  end
               end
            end
         end
         m_pclk = m_ps2_clk;
         m_pdat = m_ps2_dat;
      end
   end

   // fast monitor state
   int          f_nb = 0, f_prev_fall = 0, f_last_end = -1, f_viol = 0;
   logic        f_pclk = 1'b1, f_pdat = 1'b1;
   logic [10:0] f_bits = '0;

   // fast monitor: HP=1 timing, data-stable-while-low, and u_wrap line equality
   always @(negedge clk) begin
      logic [10:0] e;
      if (!rst_n) begin
         f_nb = 0;
         f_pclk = 1'b1;
         f_pdat = 1'b1;
      end else begin
         if (!f_pclk && !f_ps2_clk && f_ps2_dat !== f_pdat) f_viol++;
         if (w_ps2_clk !== f_ps2_clk || w_ps2_dat !== f_ps2_dat) f_viol++;
         if (f_pclk && !f_ps2_clk) begin
            if (f_nb == 0) begin
               if (f_last_end >= 0) begin
                  checks++;
                  if (cyc - f_last_end !== 3) begin
                     errors++;
                     $display("FAIL f_interframe got %0d want 3", cyc - f_last_end);
                  end
               end
            end else begin
               checks++;
               if (cyc - f_prev_fall !== 2) begin
                  errors++;
                  $display("FAIL f_bit_period got %0d want 2", cyc - f_prev_fall);
               end
            end
            f_bits[f_nb] = f_ps2_dat;
            f_nb++;
            f_prev_fall = cyc;
            if (f_nb == 11) begin
               f_nb = 0;
               f_last_end = cyc;
               checks++;
               if (fq.size() == 0) begin
                  errors++;
                  $display("FAIL f_frame unexpected frame %b", f_bits);
               end else begin
                  e = fq.pop_front();
                  if (f_bits !== e) begin
                     errors++;
                     $display("FAIL f_frame got %b want %b", f_bits, e);
                  end
               end
            end
         end
         f_pclk = f_ps2_clk;
         f_pdat = f_ps2_dat;
      end
   end

   // Caller is at a negedge; returns at the negedge after the accepting posedge.
   task automatic send_byte(input bit fast, input logic [7:0] d, input logic bad);
      logic [10:0] e;
      bit ok;
      e = {1'b1, (~^d) ^ bad, d, 1'b0};
      ok = 1'b0;
      if (fast) begin f_in_valid = 1'b1; f_in_data = d; f_in_bad = bad; end
      else      begin m_in_valid = 1'b1; m_in_data = d; m_in_bad = bad; end
      for (int n = 0; n < 400 && !ok; n++) begin
         if (fast ? (f_in_ready && w_in_ready) : m_in_ready) begin
            ok = 1'b1;
            if (fast) fq.push_back(e);
            else      mq.push_back(e);
         end
         @(negedge clk);
      end
      if (fast) f_in_valid = 1'b0;
      else      m_in_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout byte %h not accepted", d);
      end
   endtask

   task automatic wait_idle(input bit fast);
      bit done;
      done = 1'b0;
      for (int n = 0; n < 3000 && !done; n++) begin
         @(negedge clk);
         if (fast) done = (fq.size() == 0) && !f_busy && !w_busy;
         else      done = (mq.size() == 0) && !m_busy;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL wait_idle timeout fast=%0d", fast);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({m_ps2_clk, m_ps2_dat, m_busy, m_fifo_count, m_frames} !== {1'b1, 1'b1, 1'b0, 3'd0, 16'd0}) begin
         errors++;
         $display("FAIL reset_state got clk=%b dat=%b busy=%b cnt=%0d frames=%0d want 1 1 0 0 0",
                  m_ps2_clk, m_ps2_dat, m_busy, m_fifo_count, m_frames);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (m_in_ready !== 1'b1 || f_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b/%b want 1", m_in_ready, f_in_ready);
      end
   endtask

   task automatic test_single_frame();
      send_byte(1'b0, 8'hF0, 1'b0);
      checks++;
      if (m_ps2_dat !== 1'b1 || m_fifo_count !== 3'd1 || m_busy !== 1'b1) begin
         errors++;
         $display("FAIL write_cycle got dat=%b cnt=%0d busy=%b want 1 1 1", m_ps2_dat, m_fifo_count, m_busy);
      end
      @(negedge clk);
      checks++;
      if (m_ps2_dat !== 1'b0 || m_ps2_clk !== 1'b1 || m_fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL start_latency got dat=%b clk=%b cnt=%0d want 0 1 0", m_ps2_dat, m_ps2_clk, m_fifo_count);
      end
      wait_idle(1'b0);
      checks++;
      if (m_last_frame !== 11'b111_1110_0000) begin
         errors++;
         $display("FAIL frame_F0 got %b want 11111100000", m_last_frame);
      end
      checks++;
      if (m_frames !== 16'd1) begin
         errors++;
         $display("FAIL frames_sent_1 got %0d want 1", m_frames);
      end
      checks++;
      if (m_span !== 88) begin
         errors++;
         $display("FAIL frame_span got %0d want 88", m_span);
      end
   endtask

   task automatic test_bad_parity();
      // 0x1C has three ones: correct odd parity is 0, injected error sends 1
      send_byte(1'b0, 8'h1C, 1'b1);
      wait_idle(1'b0);
      checks++;
      if (m_last_frame !== 11'b110_0011_1000) begin
         errors++;
         $display("FAIL frame_1C_badpar got %b want 11000111000", m_last_frame);
      end
   endtask

   task automatic test_burst();
      m_last_end = -1;
      m_chk_gap = 1'b1;
      for (int i = 1; i <= 5; i++) send_byte(1'b0, 8'(i), 1'b0);
      checks++;
      if (m_in_ready !== 1'b0 || m_fifo_count !== 3'd4) begin
         errors++;
         $display("FAIL burst_full got ready=%b cnt=%0d want 0 4", m_in_ready, m_fifo_count);
      end
      wait_idle(1'b0);
      m_chk_gap = 1'b0;
      checks++;
      if (m_frames !== 16'd7) begin
         errors++;
         $display("FAIL frames_sent_7 got %0d want 7", m_frames);
      end
      checks++;
      if (m_viol !== 0) begin
         errors++;
         $display("FAIL m_dat_while_low got %0d want 0", m_viol);
      end
   endtask

   task automatic test_reset_midframe();
      int falls;
      bit hit;
      hit = 1'b0;
      send_byte(1'b0, 8'hAA, 1'b0);
      send_byte(1'b0, 8'h55, 1'b0);
      for (int n = 0; n < 300 && !hit; n++) begin
         @(negedge clk);
         #1;
         hit = (m_nb == 5);
      end
      checks++;
      if (!hit || m_ps2_clk !== 1'b0) begin
         errors++;
         $display("FAIL reach_bit4 got hit=%0d clk=%b want 1 0", hit, m_ps2_clk);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (m_ps2_clk !== 1'b1 || m_ps2_dat !== 1'b1) begin
         errors++;
         $display("FAIL async_reset_lines got %b%b want 11", m_ps2_clk, m_ps2_dat);
      end
      mq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      falls = m_falls;
      repeat (200) @(negedge clk);
      checks++;
      if (m_fifo_count !== 3'd0 || m_busy !== 1'b0 || m_frames !== 16'd0) begin
         errors++;
         $display("FAIL post_reset got cnt=%0d busy=%b frames=%0d want 0 0 0", m_fifo_count, m_busy, m_frames);
      end
      checks++;
      if (m_falls !== falls || m_ps2_clk !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_edges got %0d falls want 0", m_falls - falls);
      end
   endtask

   task automatic test_back_to_back();
      f_last_end = -1;
      send_byte(1'b1, 8'hA5, 1'b0);
      send_byte(1'b1, 8'h3C, 1'b1);
      wait_idle(1'b1);
      checks++;
      if (f_frames !== 16'd2) begin
         errors++;
         $display("FAIL fast_frames got %0d want 2", f_frames);
      end
      checks++;
      if (f_viol !== 0) begin
         errors++;
         $display("FAIL f_dat_while_low got %0d want 0", f_viol);
      end
   endtask

   task automatic test_wrap();
      f_last_end = -1;
      for (int i = 0; i < 15; i++) send_byte(1'b1, 8'(8'h10 + 8'(i * 7)), 1'(i % 3 == 0));
      wait_idle(1'b1);
      checks++;
      if (w_frames !== 4'd1 || f_frames !== 16'd17) begin
         errors++;
         $display("FAIL wrap got w=%0d f=%0d want 1 17", w_frames, f_frames);
      end
      checks++;
      if (f_viol !== 0 || w_fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL wrap_lines got viol=%0d cnt=%0d want 0 0", f_viol, w_fifo_count);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_bad_parity();
      test_burst();
      test_reset_midframe();
      test_back_to_back();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
